// File: rtl/datapath_arbiter_if.sv
// datapath_arbiter_if: client request/response and controller start/done bundle for datapath_arbiter
interface datapath_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           ctrl_inicio;
  logic [W-1:0]   ctrl_x;
  logic           ctrl_done;
  logic [W-1:0]   ctrl_result;
  logic           ctrl_rst;
  modport slave (
    input  req, x_in, ctrl_done, ctrl_result,
    output gnt, rsp_valid, rsp_data, rsp_err, ctrl_inicio, ctrl_x, ctrl_rst
  );
  modport master (
    output req, x_in, ctrl_done, ctrl_result,
    input  gnt, rsp_valid, rsp_data, rsp_err, ctrl_inicio, ctrl_x, ctrl_rst
  );
endinterface

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin sharing of one start/done controller among N clients; WAIT abort enabled by DP_TIMEOUT_EN
module datapath_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  datapath_arbiter_if.slave dp_io
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("datapath_arbiter: unsupported N or TIMEOUT");
  end
  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, idx_q, idx_d, win, j;
  logic [N-1:0]        gnt_q, gnt_d, vld_q, vld_d;
  logic [W-1:0]        x_q, x_d, data_q, data_d;
  logic                ini_q, ini_d, found, timeout;
  logic [N-1:0][W-1:0] xv;
  assign xv = dp_io.x_in;
  // first requester after the last served client, wrapping
  always_comb begin
    win = '0;
    j = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (!found && dp_io.req[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  // transaction sequencing and next values of every registered output
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    x_d = x_q;
    data_d = data_q;
    vld_d = '0;
    ini_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        idx_d = win;
        gnt_d = N'(1) << win;
        x_d = xv[win];
        ini_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (dp_io.ctrl_done || timeout) begin
        data_d = dp_io.ctrl_done ? dp_io.ctrl_result : '0;
        vld_d = N'(1) << idx_q;
        state_d = RESP;
      end
      default: begin
        gnt_d = '0;
        ptr_d = idx_q;
        state_d = IDLE;
      end
    endcase
  end
  // state and output registers; ptr resets to N-1 so client 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(N - 1);
      idx_q <= '0;
      gnt_q <= '0;
      vld_q <= '0;
      x_q <= '0;
      data_q <= '0;
      ini_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      x_q <= x_d;
      data_q <= data_d;
      ini_q <= ini_d;
    end
  end
`ifdef DP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, crst_q;
  assign timeout = state_q == WAIT && !dp_io.ctrl_done && cnt_q + 1'b1 == CW'(TIMEOUT);
  // WAIT cycle count (zero on entry) and error flag; a done in the timeout cycle wins
  always_comb begin
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    err_d = state_q == WAIT && (dp_io.ctrl_done || timeout) ? timeout : err_q;
  end
  // timeout registers; ctrl_rst pulses alongside the aborted response
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      crst_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      crst_q <= timeout;
    end
  end
  assign dp_io.rsp_err = err_q;
  assign dp_io.ctrl_rst = crst_q;
`else
  assign timeout = 1'b0;
  assign dp_io.rsp_err = 1'b0;
  assign dp_io.ctrl_rst = 1'b0;
`endif
  assign dp_io.gnt = gnt_q;
  assign dp_io.rsp_valid = vld_q;
  assign dp_io.rsp_data = data_q;
  assign dp_io.ctrl_inicio = ini_q;
  assign dp_io.ctrl_x = x_q;
endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: randomized round-robin checks against a queue-based reference model
module tb_datapath_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  datapath_arbiter_if #(.N(N), .W(W)) ifc ();
  datapath_arbiter #(.N(N), .W(W), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .dp_io(ifc));
  typedef struct {logic [N-1:0] g; logic [W-1:0] x; logic ino; logic [N-1:0] rq; int c;} gev_t;
  typedef struct {logic [N-1:0] v; logic [W-1:0] d; logic e; logic r; int c;} rev_t;
  gev_t gq[$];
  rev_t rq_q[$];
  int checks = 0, errors = 0, cyc = 0, n_ini = 0, n_crst = 0, n_bad = 0;
  int dly = 3, dcnt = -1, m_ptr = N - 1;
  logic spur = 1'b0;
  logic [N-1:0] prev_g = '0, rereq = '0, re_now = '0;
  logic [W-1:0] xs [N];

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_x();
    for (int i = 0; i < N; i++) ifc.x_in[i*W +: W] = xs[i];
  endtask

  task automatic tick();
    logic [N-1:0] rb;
    rb = ifc.req;
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.ctrl_inicio) n_ini++;
    if (ifc.ctrl_rst) n_crst++;
    if ((ifc.gnt & (ifc.gnt - 1'b1)) != '0) n_bad++;
    if (ifc.gnt != '0 && prev_g == '0)
      gq.push_back('{g: ifc.gnt, x: ifc.ctrl_x, ino: ifc.ctrl_inicio, rq: rb, c: cyc});
    prev_g = ifc.gnt;
    if (re_now != '0) begin
      ifc.req = ifc.req | re_now;
      re_now = '0;
    end
    if (ifc.rsp_valid != '0) begin
      rq_q.push_back('{v: ifc.rsp_valid, d: ifc.rsp_data, e: ifc.rsp_err, r: ifc.ctrl_rst, c: cyc});
      ifc.req = ifc.req & ~ifc.rsp_valid;
      re_now = ifc.rsp_valid & rereq;
      rereq = rereq & ~ifc.rsp_valid;
    end
    ifc.ctrl_done = 1'b0;
    if (spur) begin
      ifc.ctrl_done = 1'b1;
      ifc.ctrl_result = 8'hEE;
      spur = 1'b0;
    end else if (ifc.ctrl_inicio) dcnt = dly;
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        ifc.ctrl_done = 1'b1;
        ifc.ctrl_result = ifc.ctrl_x ^ 8'h2F;
        dcnt = -1;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((ifc.req != '0 || ifc.gnt != '0 || re_now != '0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle got req=%b gnt=%b after %0d cycles, want idle", nm, ifc.req, ifc.gnt, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req = '0;
    rereq = '0;
    re_now = '0;
    spur = 1'b0;
    dcnt = -1;
    ifc.ctrl_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_ptr = N - 1;
    gq.delete();
    rq_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({ifc.gnt, ifc.rsp_valid, ifc.rsp_err, ifc.ctrl_inicio, ifc.ctrl_rst} !== '0) begin
      errors++;
      $display("FAIL reset_flags got gnt=%b vld=%b err=%b ini=%b crst=%b want all 0",
               ifc.gnt, ifc.rsp_valid, ifc.rsp_err, ifc.ctrl_inicio, ifc.ctrl_rst);
    end
    checks++;
    if (ifc.rsp_data !== '0 || ifc.ctrl_x !== '0) begin
      errors++;
      $display("FAIL reset_data got rsp_data=%h ctrl_x=%h want 00 00", ifc.rsp_data, ifc.ctrl_x);
    end
  endtask

  task automatic test_single();
    int b = n_ini;
    xs[0] = 8'h05;
    set_x();
    dly = 9;
    gq.delete();
    rq_q.delete();
    ifc.req = 4'b0001;
    wait_idle(60, "single");
    checks++;
    if (gq.size() != 1 || rq_q.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d grants %0d rsps want 1 1", gq.size(), rq_q.size());
    end
    checks++;
    if (gq[0].g !== 4'b0001 || gq[0].x !== 8'h05 || gq[0].ino !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got gnt=%b x=%h ini=%b want 0001 05 1", gq[0].g, gq[0].x, gq[0].ino);
    end
    checks++;
    if (n_ini - b != 1) begin
      errors++;
      $display("FAIL single_inicio got %0d pulses want 1", n_ini - b);
    end
    checks++;
    if (rq_q[0].v !== 4'b0001 || rq_q[0].d !== 8'h2A || rq_q[0].e !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got vld=%b data=%h err=%b want 0001 2a 0", rq_q[0].v, rq_q[0].d, rq_q[0].e);
    end
    checks++;
    if (rq_q[0].c - gq[0].c != 10) begin
      errors++;
      $display("FAIL single_latency got %0d cycles issue->rsp want 10", rq_q[0].c - gq[0].c);
    end
    m_ptr = 0;
  endtask

  task automatic test_contention();
    int cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      xs[i] = W'($urandom);
      cnt[i] = 0;
    end
    set_x();
    dly = $urandom_range(1, 6);
    ifc.req = '1;
    wait_idle(300, "contention");
    checks++;
    if (gq.size() != N || rq_q.size() != N) begin
      errors++;
      $display("FAIL contention_count got %0d grants %0d rsps want %0d", gq.size(), rq_q.size(), N);
    end
    for (int i = 0; i < gq.size() && i < rq_q.size(); i++) begin
      logic [N-1:0] eg;
      int e;
      e = rr(gq[i].rq, m_ptr);
      eg = '0;
      eg[e] = 1'b1;
      checks++;
      if (gq[i].g !== eg || gq[i].x !== xs[e] || gq[i].ino !== 1'b1) begin
        errors++;
        $display("FAIL contention_grant[%0d] got gnt=%b x=%h ini=%b want %b %h 1", i, gq[i].g, gq[i].x, gq[i].ino, eg, xs[e]);
      end
      checks++;
      if (rq_q[i].v !== eg || rq_q[i].d !== (xs[e] ^ 8'h2F)) begin
        errors++;
        $display("FAIL contention_rsp[%0d] got vld=%b data=%h want %b %h", i, rq_q[i].v, rq_q[i].d, eg, xs[e] ^ 8'h2F);
      end
      for (int k = 0; k < N; k++) cnt[k] += int'(rq_q[i].v[k]);
      m_ptr = e;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cnt[k] != 1) begin
        errors++;
        $display("FAIL contention_pulses client %0d got %0d want 1", k, cnt[k]);
      end
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL gnt_onehot got %0d multi-hot cycles want 0", n_bad);
    end
  endtask

  task automatic test_fairness();
    int ord [3] = '{1, 2, 1};
    do_reset();
    for (int i = 0; i < N; i++) xs[i] = W'($urandom);
    set_x();
    dly = $urandom_range(1, 5);
    rereq = 4'b0010;
    ifc.req = 4'b0110;
    wait_idle(200, "fairness");
    checks++;
    if (gq.size() != 3 || rq_q.size() != 3) begin
      errors++;
      $display("FAIL fairness_count got %0d grants %0d rsps want 3 3", gq.size(), rq_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[ord[i]] = 1'b1;
      checks++;
      if (gq[i].g !== eg || rq_q[i].v !== eg || rq_q[i].d !== (xs[ord[i]] ^ 8'h2F)) begin
        errors++;
        $display("FAIL fairness_order[%0d] got gnt=%b vld=%b data=%h want %b %b %h",
                 i, gq[i].g, rq_q[i].v, rq_q[i].d, eg, eg, xs[ord[i]] ^ 8'h2F);
      end
    end
    m_ptr = 1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 15; r++) begin
      logic [N-1:0] m;
      int tot;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) xs[i] = W'($urandom);
      set_x();
      dly = $urandom_range(1, 8);
      rereq = N'($urandom) & m;
      tot = $countones(m) + $countones(rereq);
      gq.delete();
      rq_q.delete();
      ifc.req = m;
      wait_idle(400, "random");
      checks++;
      if (gq.size() != tot || rq_q.size() != tot) begin
        errors++;
        $display("FAIL random_count round %0d got %0d grants %0d rsps want %0d", r, gq.size(), rq_q.size(), tot);
      end
      for (int i = 0; i < gq.size() && i < rq_q.size(); i++) begin
        logic [N-1:0] eg;
        int e;
        e = rr(gq[i].rq, m_ptr);
        eg = '0;
        eg[e] = 1'b1;
        checks++;
        if (gq[i].g !== eg || gq[i].x !== xs[e] || rq_q[i].v !== eg || rq_q[i].d !== (xs[e] ^ 8'h2F) || rq_q[i].e !== 1'b0) begin
          errors++;
          $display("FAIL random_txn round %0d #%0d got gnt=%b x=%h vld=%b data=%h err=%b want %b %h %b %h 0",
                   r, i, gq[i].g, gq[i].x, rq_q[i].v, rq_q[i].d, rq_q[i].e, eg, xs[e], eg, xs[e] ^ 8'h2F);
        end
        m_ptr = e;
      end
    end
  endtask

  task automatic test_spurious();
    gq.delete();
    rq_q.delete();
    spur = 1'b1;
    repeat (5) tick();
    checks++;
    if (gq.size() != 0 || rq_q.size() != 0) begin
      errors++;
      $display("FAIL spurious_idle got %0d grants %0d rsps want 0 0", gq.size(), rq_q.size());
    end
    xs[2] = W'($urandom);
    set_x();
    dly = 4;
    ifc.req = 4'b0100;
    wait_idle(60, "spurious");
    checks++;
    if (gq.size() != 1 || rq_q.size() != 1 || rq_q[0].v !== 4'b0100 || rq_q[0].d !== (xs[2] ^ 8'h2F)) begin
      errors++;
      $display("FAIL spurious_txn got %0d rsps vld=%b data=%h want 1 0100 %h", rq_q.size(), rq_q[0].v, rq_q[0].d, xs[2] ^ 8'h2F);
    end
    m_ptr = 2;
  endtask

  task automatic test_rst_in_wait();
    int n = 0;
    gq.delete();
    rq_q.delete();
    dly = -1;
    ifc.req = 4'b0100;
    while (ifc.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rstwait_grant got gnt=%b want 0100", ifc.gnt);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ifc.gnt, ifc.rsp_valid, ifc.rsp_err, ifc.ctrl_inicio, ifc.ctrl_rst} !== '0 || ifc.rsp_data !== '0 || ifc.ctrl_x !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs got gnt=%b vld=%b data=%h x=%h want all 0", ifc.gnt, ifc.rsp_valid, ifc.rsp_data, ifc.ctrl_x);
    end
    rst = 1'b0;
    ifc.req = '0;
    dcnt = -1;
    m_ptr = N - 1;
    repeat (2) tick();
    checks++;
    if (rq_q.size() != 0) begin
      errors++;
      $display("FAIL rstwait_norsp got %0d rsps want 0", rq_q.size());
    end
    gq.delete();
    for (int i = 0; i < N; i++) xs[i] = W'($urandom);
    set_x();
    dly = 2;
    ifc.req = 4'b1001;
    wait_idle(100, "rstwait");
    checks++;
    if (gq.size() != 2 || gq[0].g !== 4'b0001 || gq[1].g !== 4'b1000 || rq_q[0].d !== (xs[0] ^ 8'h2F)) begin
      errors++;
      $display("FAIL rstwait_after got %0d grants first=%b second=%b data=%h want 2 0001 1000 %h",
               gq.size(), gq[0].g, gq[1].g, rq_q[0].d, xs[0] ^ 8'h2F);
    end
    m_ptr = 3;
  endtask

  task automatic test_timeout();
    int b = n_crst;
    gq.delete();
    rq_q.delete();
    xs[0] = W'($urandom);
    xs[1] = W'($urandom);
    set_x();
`ifdef DP_TIMEOUT_EN
    dly = -1;
    ifc.req = 4'b0001;
    wait_idle(100, "timeout");
    checks++;
    if (rq_q.size() != 1 || rq_q[0].v !== 4'b0001 || rq_q[0].e !== 1'b1 || rq_q[0].d !== 8'h00 || rq_q[0].r !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rsp got vld=%b err=%b data=%h crst=%b want 0001 1 00 1", rq_q[0].v, rq_q[0].e, rq_q[0].d, rq_q[0].r);
    end
    checks++;
    if (n_crst - b != 1 || rq_q[0].c - gq[0].c != TMO + 1) begin
      errors++;
      $display("FAIL timeout_timing got %0d ctrl_rst pulses, %0d cycles want 1 %0d", n_crst - b, rq_q[0].c - gq[0].c, TMO + 1);
    end
`else
    dly = 30;
    ifc.req = 4'b0001;
    wait_idle(100, "longwait");
    checks++;
    if (rq_q.size() != 1 || rq_q[0].e !== 1'b0 || rq_q[0].d !== (xs[0] ^ 8'h2F) || n_crst != b) begin
      errors++;
      $display("FAIL longwait_rsp got err=%b data=%h crst=%0d want 0 %h 0", rq_q[0].e, rq_q[0].d, n_crst - b, xs[0] ^ 8'h2F);
    end
    checks++;
    if (rq_q[0].c - gq[0].c != 31) begin
      errors++;
      $display("FAIL longwait_timing got %0d cycles want 31", rq_q[0].c - gq[0].c);
    end
`endif
    rq_q.delete();
    dly = 3;
    ifc.req = 4'b0010;
    wait_idle(60, "after_wait");
    checks++;
    if (rq_q.size() != 1 || rq_q[0].v !== 4'b0010 || rq_q[0].e !== 1'b0 || rq_q[0].d !== (xs[1] ^ 8'h2F)) begin
      errors++;
      $display("FAIL after_wait_rsp got vld=%b err=%b data=%h want 0010 0 %h", rq_q[0].v, rq_q[0].e, rq_q[0].d, xs[1] ^ 8'h2F);
    end
  endtask

  initial begin
    ifc.req = '0;
    ifc.x_in = '0;
    ifc.ctrl_done = 1'b0;
    ifc.ctrl_result = '0;
    for (int i = 0; i < N; i++) xs[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_spurious();
    test_rst_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
